// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - shared types, constants and helpers for the sound frame streamer
package sound_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_PLAY    = 2'd2
  } state_t;

  localparam int MIN_DIV = 2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sound_frame_fifo.sv
// rtl/sound_frame_fifo.sv - single-clock first-word-fall-through frame FIFO with level and clear
module sound_frame_fifo #(
  parameter int W  = 32,
  parameter int AW = 11
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic [AW:0]   o_level,
  output logic          o_full,
  output logic          o_empty
);

  logic [W-1:0]  r_mem [0:(1<<AW)-1];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_level;
  logic          w_push_ok;
  logic          w_pop_ok;

  // Clear wins over both push and pop in the same cycle.
  assign w_push_ok = i_push && !o_full && !i_clr;
  assign w_pop_ok  = i_pop && !o_empty && !i_clr;

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else if (i_clr) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + AW'(1);
      if (w_pop_ok)  r_rd <= r_rd + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd];
  assign o_level = r_level;
  assign o_full  = r_level[AW];
  assign o_empty = (r_level == '0);

endmodule

// File: rtl/sound_stream.sv
// rtl/sound_stream.sv - N-channel audio frame streamer with prefill, paced output and underrun handling
module sound_stream #(
  parameter int CHANNELS   = 2,
  parameter int SAMPLE_W   = 16,
  parameter int DEPTH_LOG2 = 11,
  parameter int DIV_W      = 16
) (
  input  logic                         clk_sys,
  input  logic                         sound_reset,
  input  logic                         sound_enabled,
  input  logic                         sound_synced,
  input  logic                         sound_flush,
  input  logic                         hold_on_underrun,
  input  logic                         start_gate,
  input  logic [3:0]                   chan_count,
  input  logic [DIV_W-1:0]             clocks_per_sample,
  input  logic [DEPTH_LOG2:0]          prefill,
  input  logic                         wr_valid,
  input  logic [CHANNELS*SAMPLE_W-1:0] wr_data,
  output logic                         wr_ready,
  output logic [CHANNELS*SAMPLE_W-1:0] smp_data,
  output logic                         smp_strobe,
  output logic [DEPTH_LOG2:0]          fill_level,
  output logic [15:0]                  underrun_cnt,
  output logic                         playing
);
  import sound_pkg::*;

  localparam int FW = CHANNELS * SAMPLE_W;
  localparam logic [DEPTH_LOG2:0] DEPTH_L = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [3:0] CH_L = 4'(CHANNELS);

  state_t              r_state, w_state_nxt;
  logic [DIV_W-1:0]    r_div, w_cps;
  logic [DEPTH_LOG2:0] r_debt, w_debt_nxt, w_prefill, w_level;
  logic [FW-1:0]       r_smp, w_head, w_masked;
  logic [15:0]         r_urun;
  logic [3:0]          w_eff;
  logic                r_strobe;
  logic w_full, w_empty, w_accept, w_discard, w_push, w_tick, w_underrun, w_clr, w_stop;

  assign w_cps      = (clocks_per_sample < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : clocks_per_sample;
  assign w_prefill  = (prefill > DEPTH_L) ? DEPTH_L : prefill;
  assign w_stop     = (r_state == ST_PLAY) && !sound_enabled;
  assign w_clr      = sound_flush || w_stop;
  assign w_tick     = (r_state == ST_PLAY) && sound_enabled && (r_div == w_cps - DIV_W'(1));
  assign w_underrun = w_tick && w_empty;
  assign wr_ready   = sound_enabled && !w_full && !sound_reset;
  assign w_accept   = wr_valid && wr_ready;
  // Drift compensation: while behind, drop incoming frames instead of storing them.
  assign w_discard  = w_accept && (r_state == ST_PLAY) && !sound_synced && (r_debt != '0);
  assign w_push     = w_accept && !w_discard;

  sound_frame_fifo #(.W(FW), .AW(DEPTH_LOG2)) u_fifo (
    .i_clk   (clk_sys),
    .i_rst   (sound_reset),
    .i_clr   (w_clr),
    .i_push  (w_push),
    .i_data  (wr_data),
    .i_pop   (w_tick),
    .o_data  (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (sound_enabled) w_state_nxt = ST_PREFILL;
      ST_PREFILL: if ((w_level >= w_prefill) && start_gate) w_state_nxt = ST_PLAY;
      ST_PLAY:    if (!sound_enabled) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
    if (sound_flush) w_state_nxt = ST_IDLE;
  end

  always_comb begin
    w_masked = '0;
    w_eff    = (chan_count > CH_L) ? CH_L : chan_count;
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_eff == 4'd1)
        w_masked[c*SAMPLE_W +: SAMPLE_W] = w_head[SAMPLE_W-1:0];
      else if (c < 32'(w_eff))
        w_masked[c*SAMPLE_W +: SAMPLE_W] = w_head[c*SAMPLE_W +: SAMPLE_W];
    end
  end

  always_comb begin
    w_debt_nxt = r_debt;
    if (w_underrun && (r_debt != DEPTH_L)) w_debt_nxt = w_debt_nxt + (DEPTH_LOG2+1)'(1);
    if (w_discard) w_debt_nxt = w_debt_nxt - (DEPTH_LOG2+1)'(1);
  end

  always_ff @(posedge clk_sys or posedge sound_reset) begin
    if (sound_reset) begin
      r_state  <= ST_IDLE;
      r_div    <= '0;
      r_smp    <= '0;
      r_strobe <= 1'b0;
      r_urun   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_strobe <= 1'b0;
      if (sound_flush) begin
        r_div  <= '0;
        r_smp  <= '0;
        r_urun <= '0;
      end else if ((r_state != ST_PLAY) || w_stop) begin
        r_div <= '0;
        r_smp <= '0;
      end else begin
        r_div <= w_tick ? '0 : r_div + DIV_W'(1);
        if (w_tick) begin
          r_strobe <= 1'b1;
          if (!w_empty) begin
            r_smp <= w_masked;
          end else begin
            if (!hold_on_underrun) r_smp <= '0;
            r_urun <= sat_inc16(r_urun);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_sys or posedge sound_reset) begin
    if (sound_reset)                     r_debt <= '0;
    else if (sound_flush || sound_synced) r_debt <= '0;
    else                                  r_debt <= w_debt_nxt;
  end

  assign smp_data     = r_smp;
  assign smp_strobe   = r_strobe;
  assign fill_level   = w_level;
  assign underrun_cnt = r_urun;
  assign playing      = (r_state == ST_PLAY);

endmodule

// File: tb/tb_sound_stream.sv
// tb/tb_sound_stream.sv - directed self-checking bench for sound_stream
module tb_sound_stream;

  logic        clk_sys = 1'b0;
  logic        sound_reset, sound_enabled, sound_synced, sound_flush;
  logic        hold_on_underrun, start_gate;
  logic [3:0]  chan_count;
  logic [7:0]  clocks_per_sample;
  logic [3:0]  prefill;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic [31:0] smp_data;
  logic        smp_strobe;
  logic [3:0]  fill_level;
  logic [15:0] underrun_cnt;
  logic        playing;

  int n_checks = 0;
  int n_errors = 0;
  int n;

  sound_stream #(.CHANNELS(2), .SAMPLE_W(16), .DEPTH_LOG2(3), .DIV_W(8)) dut (
    .clk_sys           (clk_sys),
    .sound_reset       (sound_reset),
    .sound_enabled     (sound_enabled),
    .sound_synced      (sound_synced),
    .sound_flush       (sound_flush),
    .hold_on_underrun  (hold_on_underrun),
    .start_gate        (start_gate),
    .chan_count        (chan_count),
    .clocks_per_sample (clocks_per_sample),
    .prefill           (prefill),
    .wr_valid          (wr_valid),
    .wr_data           (wr_data),
    .wr_ready          (wr_ready),
    .smp_data          (smp_data),
    .smp_strobe        (smp_strobe),
    .fill_level        (fill_level),
    .underrun_cnt      (underrun_cnt),
    .playing           (playing)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    cyc();
    wr_valid = 1'b0;
  endtask

  task automatic wait_strobe(output int cnt);
    cnt = 0;
    cyc();
    cnt = 1;
    while (!smp_strobe && cnt < 40) begin
      cyc();
      cnt++;
    end
    chk("strobe_seen", {31'd0, smp_strobe}, 32'd1);
  endtask

  function automatic logic [31:0] fa(input int i);
    return {16'hB000 + 16'(i), 16'hA000 + 16'(i)};
  endfunction

  function automatic logic [31:0] fc(input int i);
    return (i == 5) ? 32'hABCD_1234 : {16'hC100 + 16'(i), 16'hC000 + 16'(i)};
  endfunction

  function automatic logic [31:0] fd(input int i);
    return {16'hD100 + 16'(i), 16'hD000 + 16'(i)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sound_reset = 1'b1; sound_enabled = 1'b0; sound_synced = 1'b1; sound_flush = 1'b0;
    hold_on_underrun = 1'b1; start_gate = 1'b1; chan_count = 4'd2;
    clocks_per_sample = 8'd8; prefill = 4'd4; wr_valid = 1'b0; wr_data = '0;
    repeat (3) cyc();
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_smp_data", smp_data, 32'd0);
    chk("rst_strobe", {31'd0, smp_strobe}, 32'd0);
    chk("rst_fill", {28'd0, fill_level}, 32'd0);
    chk("rst_underrun", {16'd0, underrun_cnt}, 32'd0);
    chk("rst_playing", {31'd0, playing}, 32'd0);

    sound_reset = 1'b0;
    cyc();
    sound_enabled = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      push(fa(i));
      if (i == 4) begin
        chk("prefill_level4", {28'd0, fill_level}, 32'd4);
        chk("prefill_not_playing", {31'd0, playing}, 32'd0);
      end
    end
    chk("play_started", {31'd1 & 32'(playing)}, 32'd1);

    for (int k = 1; k <= 5; k++) begin
      wait_strobe(n);
      chk("tick_interval", 32'(n), 32'd8);
      chk("frame_order", smp_data, fa(k));
    end

    wait_strobe(n);
    chk("underrun_interval", 32'(n), 32'd8);
    chk("hold_repeat", smp_data, fa(5));
    chk("underrun_cnt1", {16'd0, underrun_cnt}, 32'd1);
    chk("underrun_fill", {28'd0, fill_level}, 32'd0);

    hold_on_underrun = 1'b0;
    wait_strobe(n);
    chk("zero_mode", smp_data, 32'd0);
    chk("underrun_cnt2", {16'd0, underrun_cnt}, 32'd2);

    sound_synced = 1'b0;
    repeat (3) wait_strobe(n);
    chk("underrun_cnt5", {16'd0, underrun_cnt}, 32'd5);

    for (int i = 0; i <= 5; i++) push(fc(i));
    chk("debt_discard_fill", {28'd0, fill_level}, 32'd3);
    wait_strobe(n);
    chk("first_kept_frame", smp_data, fc(3));
    chk("fill_after_pop", {28'd0, fill_level}, 32'd2);

    sound_synced = 1'b1;
    for (int i = 0; i <= 4; i++) push(fd(i));
    chk("synced_all_stored", {28'd0, fill_level}, 32'd7);
    push(32'hEEEE_EEEE);
    chk("full_level", {28'd0, fill_level}, 32'd8);
    chk("full_wr_ready", {31'd0, wr_ready}, 32'd0);
    wr_valid = 1'b1;
    wr_data  = 32'hFFFF_0000;
    wait_strobe(n);
    chk("after_full_pop_level", {28'd0, fill_level}, 32'd7);
    chk("after_full_pop_ready", {31'd0, wr_ready}, 32'd1);
    chk("after_full_pop_data", smp_data, fc(4));
    wr_valid = 1'b0;

    chan_count = 4'd1;
    wait_strobe(n);
    chk("mono_dup", smp_data, 32'h1234_1234);
    chan_count = 4'd0;
    wait_strobe(n);
    chk("mute", smp_data, 32'd0);
    chan_count = 4'd15;
    wait_strobe(n);
    chk("chan_clamp", smp_data, fd(1));

    #3;
    sound_reset = 1'b1;
    #1;
    chk("async_rst_playing", {31'd0, playing}, 32'd0);
    chk("async_rst_fill", {28'd0, fill_level}, 32'd0);
    chk("async_rst_data", smp_data, 32'd0);
    chk("async_rst_strobe", {31'd0, smp_strobe}, 32'd0);
    chk("async_rst_underrun", {16'd0, underrun_cnt}, 32'd0);
    chk("async_rst_ready", {31'd0, wr_ready}, 32'd0);
    cyc();
    sound_reset = 1'b0;
    cyc();

    push(32'h1111_0001);
    push(32'h1111_0002);
    chk("pre_flush_fill", {28'd0, fill_level}, 32'd2);
    sound_flush = 1'b1;
    wr_valid    = 1'b1;
    wr_data     = 32'h1111_0003;
    cyc();
    sound_flush = 1'b0;
    wr_valid    = 1'b0;
    chk("flush_fill", {28'd0, fill_level}, 32'd0);
    chk("flush_playing", {31'd0, playing}, 32'd0);

    prefill = 4'd1;
    clocks_per_sample = 8'd0;
    push(32'h2222_0001);
    push(32'h2222_0002);
    push(32'h2222_0003);
    wait_strobe(n);
    chk("min_div_first", smp_data, 32'h2222_0001);
    wait_strobe(n);
    chk("min_div_interval", 32'(n), 32'd2);
    chk("min_div_second", smp_data, 32'h2222_0002);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
